vaddsub_sequencer: RTL and testbench

//  Issue/collect controller for the 3-stage FP16 add/sub unit (vaddsub). Accepts one LANES-wide

---
 rtl/vector_pkg.sv | 18 +
 rtl/lat_pipe.sv | 31 +++
 rtl/vaddsub_sequencer.sv | 144 ++++++++++++++
 tb/tb_vaddsub_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector FP16 datapath.
//   fp16_t       : one IEEE half-precision element (raw bits)
//   seq_state_t  : control states of the vaddsub issue/collect sequencer
//   VADDSUB_LAT  : cycles from vaddsub enable sampled to its output being valid
package vector_pkg;

   typedef logic [15:0] fp16_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } seq_state_t;

   localparam int VADDSUB_LAT = 3;

endpackage

// File: rtl/lat_pipe.sv
// Fixed-depth shift register that carries in-flight lane tags alongside the
// vaddsub pipeline, so each result can be matched to the lane it belongs to.
// Ports:
//   CLK   in  1  clock, rising edge
//   nRST  in  1  asynchronous active-low reset (clears every stage)
//   din   in  W  tag entering the pipe this cycle
//   dout  out W  tag that entered DEPTH cycles ago
module lat_pipe #(
   parameter int DEPTH = 3,
   parameter int W     = 4
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vaddsub_sequencer.sv
// Issue/collect controller for the pipelined FP16 add/sub unit. Accepts one
// LANES-wide vector op, streams one lane per cycle into the unit, collects
// each lane's result after the fixed pipeline latency and presents the full
// vector with a sticky overflow flag.
// Ports:
//   CLK, nRST               clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake
//   req_sub, req_a, req_b   op select (1 = A-B) and packed operands (lane i = [16i+15:16i])
//   rsp_valid/rsp_ready     response handshake
//   rsp_out, rsp_ovf        packed result vector and OR of per-lane overflow
//   au_port_a/b, au_sub,    drive side of the add/sub unit
//   au_enable
//   au_out, au_overflow     result side of the add/sub unit
module vaddsub_sequencer
   import vector_pkg::*;
#(
   parameter  int LANES = 8,
   parameter  int LAT   = VADDSUB_LAT,
   localparam int IDXW  = $clog2(LANES > 1 ? LANES : 2)
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_sub,
   input  logic [LANES*16-1:0] req_a,
   input  logic [LANES*16-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [LANES*16-1:0] rsp_out,
   output logic               rsp_ovf,
   output logic [15:0]        au_port_a,
   output logic [15:0]        au_port_b,
   output logic               au_sub,
   output logic               au_enable,
   input  logic [15:0]        au_out,
   input  logic               au_overflow
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);
   localparam logic [IDXW:0]   LAST_CAP = (IDXW + 1)'(LANES - 1);

   seq_state_t          state, state_nxt;
   logic [IDXW-1:0]     issue_idx;
   logic [IDXW:0]       cap_cnt;
   logic [LANES*16-1:0] op_a, op_b;
   logic                op_sub;
   logic [LANES*16-1:0] res_buf;
   logic                ovf;

   logic                accept;
   logic [IDXW:0]       tag_in, tag_out;
   logic                cap_vld;
   logic [IDXW-1:0]     cap_idx;

   assign accept  = (state == IDLE) && req_valid;
   assign tag_in  = {au_enable, issue_idx};
   assign cap_vld = tag_out[IDXW];
   assign cap_idx = tag_out[IDXW-1:0];
   assign rsp_out = res_buf;
   assign rsp_ovf = ovf;

   // The tag pipe, not the unit's own valid, decides which cycle's result belongs to which lane.
   lat_pipe #(
      .DEPTH (LAT),
      .W     (IDXW + 1)
   ) u_tags (
      .CLK  (CLK),
      .nRST (nRST),
      .din  (tag_in),
      .dout (tag_out)
   );

   always_comb begin
      fp16_t lane_a, lane_b;
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      au_enable = 1'b0;
      au_port_a = '0;
      au_port_b = '0;
      au_sub    = 1'b0;
      lane_a    = op_a[16*int'(issue_idx) +: 16];
      lane_b    = op_b[16*int'(issue_idx) +: 16];
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            au_enable = 1'b1;
            au_port_a = lane_a;
            au_port_b = lane_b;
            au_sub    = op_sub;
            if (issue_idx == LAST_IDX) state_nxt = DRAIN;
         end
         DRAIN: begin
            // The last lane always lands here, because capture trails issue by LAT cycles.
            if (cap_vld && cap_cnt == LAST_CAP) state_nxt = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage boundary: control state, counters and the collected result vector.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         issue_idx <= '0;
         cap_cnt   <= '0;
         res_buf   <= '0;
         ovf       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            issue_idx <= '0;
            cap_cnt   <= '0;
            res_buf   <= '0;
            ovf       <= 1'b0;
         end else begin
            if (state == ISSUE && issue_idx != LAST_IDX) issue_idx <= issue_idx + 1'b1;
            if (cap_vld) begin
               res_buf[16*int'(cap_idx) +: 16] <= au_out;
               ovf                            <= ovf | au_overflow;
               cap_cnt                        <= cap_cnt + 1'b1;
            end
         end
      end
   end

   // Stage boundary: operand latch. Only read while issuing, so it needs no reset.
   always_ff @(posedge CLK) begin
      if (accept) begin
         op_a   <= req_a;
         op_b   <= req_b;
         op_sub <= req_sub;
      end
   end

endmodule

// File: tb/tb_vaddsub_sequencer.sv
module tb_vaddsub_sequencer;

   localparam int LANES = 8;
   localparam int LAT   = 3;
   localparam int VW    = LANES * 16;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          req_valid, req_ready, req_sub;
   logic [VW-1:0] req_a, req_b;
   logic          rsp_valid, rsp_ready;
   logic [VW-1:0] rsp_out;
   logic          rsp_ovf;
   logic [15:0]   au_port_a, au_port_b, au_out;
   logic          au_sub, au_enable, au_overflow;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   vaddsub_sequencer #(.LANES(LANES), .LAT(LAT)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_sub     (req_sub),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_out     (rsp_out),
      .rsp_ovf     (rsp_ovf),
      .au_port_a   (au_port_a),
      .au_port_b   (au_port_b),
      .au_sub      (au_sub),
      .au_enable   (au_enable),
      .au_out      (au_out),
      .au_overflow (au_overflow)
   );

   // ---------------- FP16 arithmetic reference (exact sum, round to nearest even) ----------------
   function automatic longint h2fix(logic [15:0] h);
      longint mag;
      if (h[14:10] == 5'd0) mag = longint'(h[9:0]);
      else                  mag = longint'({1'b1, h[9:0]}) << (int'(h[14:10]) - 1);
      return h[15] ? -mag : mag;
   endfunction

   // Returns {overflow, result}.
   function automatic logic [16:0] fp_addsub(logic [15:0] a, logic [15:0] b, logic sub);
      longint s, m, rem, half, sig;
      int     p, sh, e;
      logic   sg;
      s = h2fix(a) + (sub ? -h2fix(b) : h2fix(b));
      if (s == 0) return 17'd0;
      sg = (s < 0);
      m  = sg ? -s : s;
      if (m < 1024) return {1'b0, sg, 5'd0, m[9:0]};
      p = 0;
      for (int i = 0; i < 63; i++) if (m[i]) p = i;
      sh   = p - 10;
      sig  = m >> sh;
      rem  = m & ((longint'(1) << sh) - 1);
      half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
      if (rem > half || (sh > 0 && rem == half && sig[0])) sig = sig + 1;
      if (sig == 2048) begin
         sig = 1024;
         sh  = sh + 1;
      end
      e = sh + 1;
      if (e >= 31) return {1'b1, sg, 5'h1F, 10'h000};
      return {1'b0, sg, e[4:0], sig[9:0]};
   endfunction

   // ---------------- Stand-in for the 3-stage vaddsub unit ----------------
   // Idle cycles produce a poison value with overflow set, so spurious captures are visible.
   logic [16:0] au_p0, au_p1, au_p2;
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         au_p0 <= '0;
         au_p1 <= '0;
         au_p2 <= '0;
      end else begin
         au_p0 <= au_enable ? fp_addsub(au_port_a, au_port_b, au_sub) : {1'b1, 16'hDEAD};
         au_p1 <= au_p0;
         au_p2 <= au_p1;
      end
   end
   assign au_out      = au_p2[15:0];
   assign au_overflow = au_p2[16];

   // ---------------- Check helpers ----------------
   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkv(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Wait for an idle sequencer, present an op, return just after the accepting edge.
   task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic sub);
      int w;
      w = 0;
      @(negedge CLK);
      while (!req_ready && w < 100) begin
         @(negedge CLK);
         w++;
      end
      chk1("issue_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_sub   = sub;
      @(posedge CLK);
   endtask

   // Called right after the accepting edge. Checks enable count, response latency and
   // the vector; ack_delay < 0 leaves the response pending at a negedge.
   task automatic collect(input logic [VW-1:0] exp_v, input logic exp_o, input int ack_delay,
                          input bit noise);
      int k, en_cnt;
      bit seen;
      k = 0; en_cnt = 0; seen = 0;
      while (k < 200) begin
         @(negedge CLK);
         req_valid = 1'b0;
         if (rsp_valid) begin
            seen = 1;
            break;
         end
         if (au_enable) en_cnt++;
         rsp_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge CLK);
         k++;
      end
      rsp_ready = 1'b0;
      chk1("rsp_seen", 1'(seen), 1'b1);
      chki("rsp_latency", k, LANES + LAT);
      chki("enable_cycles", en_cnt, LANES);
      chkv("rsp_out", rsp_out, exp_v);
      chk1("rsp_ovf", rsp_ovf, exp_o);
      if (ack_delay >= 0) begin
         for (int d = 0; d < ack_delay; d++) begin
            @(negedge CLK);
            chk1("hold_valid", rsp_valid, 1'b1);
            chkv("hold_out", rsp_out, exp_v);
         end
         rsp_ready = 1'b1;
         @(posedge CLK);
         @(negedge CLK);
         rsp_ready = 1'b0;
         chk1("post_ack_valid", rsp_valid, 1'b0);
         chk1("post_ack_ready", req_ready, 1'b1);
      end
   endtask

   function automatic logic [VW-1:0] splat(logic [15:0] h);
      logic [VW-1:0] v;
      for (int i = 0; i < LANES; i++) v[16*i +: 16] = h;
      return v;
   endfunction

   function automatic logic [15:0] rand_h();
      logic [15:0] h;
      h = 16'($urandom);
      if (h[14:10] == 5'h1F) h[14:10] = 5'h1E;
      return h;
   endfunction

   typedef struct {
      logic          sub;
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      logic [VW-1:0] x;
      logic          o;
   } vec_t;

   vec_t tbl[4];

   initial begin
      logic [VW-1:0] ra, rb, rx;
      logic          rs, ro;
      logic [16:0]   r;
      logic [15:0]   bsub [LANES];
      logic [15:0]   xsub [LANES];

      // Directed vector table
      tbl[0] = '{1'b0, splat(16'h3C00), splat(16'h3C00), splat(16'h4000), 1'b0};
      bsub = '{16'h3C00, 16'h4000, 16'h3800, 16'h0000, 16'h3E00, 16'hBC00, 16'h4400, 16'h4200};
      xsub = '{16'h4000, 16'h3C00, 16'h4100, 16'h4200, 16'h3E00, 16'h4400, 16'hBC00, 16'h0000};
      tbl[1].sub = 1'b1;
      tbl[1].a   = splat(16'h4200);
      tbl[1].o   = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         tbl[1].b[16*i +: 16] = bsub[i];
         tbl[1].x[16*i +: 16] = xsub[i];
      end
      tbl[2] = '{1'b0, splat(16'h3C00), splat(16'h3C00), splat(16'h4000), 1'b1};
      tbl[2].a[80 +: 16] = 16'h7BFF;
      tbl[2].b[80 +: 16] = 16'h7BFF;
      tbl[2].x[80 +: 16] = 16'h7C00;
      tbl[3] = '{1'b0, splat(16'h4000), splat(16'h3C00), splat(16'h4200), 1'b0};

      // Reset state
      nRST = 1'b0; req_valid = 1'b0; req_sub = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (5) @(negedge CLK);
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_au_enable", au_enable, 1'b0);
      chkv("rst_rsp_out", rsp_out, '0);
      chk1("rst_rsp_ovf", rsp_ovf, 1'b0);
      chkv("rst_au_port_a", VW'(au_port_a), '0);
      nRST = 1'b1;

      // Table-driven ops
      for (int t = 0; t < 4; t++) begin
         issue(tbl[t].a, tbl[t].b, tbl[t].sub);
         collect(tbl[t].x, tbl[t].o, t % 3, 1'b0);
      end

      // Backpressure in DONE with a new request waiting
      issue(tbl[0].a, tbl[0].b, tbl[0].sub);
      collect(tbl[0].x, tbl[0].o, -1, 1'b0);
      req_valid = 1'b1; req_a = tbl[1].a; req_b = tbl[1].b; req_sub = tbl[1].sub;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK);
         @(negedge CLK);
         chk1("bp_valid", rsp_valid, 1'b1);
         chkv("bp_out", rsp_out, tbl[0].x);
         chk1("bp_req_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      rsp_ready = 1'b0;
      chk1("bp_idle_ready", req_ready, 1'b1);
      chk1("bp_idle_valid", rsp_valid, 1'b0);
      chkv("bp_idle_out_kept", rsp_out, tbl[0].x);
      @(posedge CLK);
      collect(tbl[1].x, tbl[1].o, 0, 1'b0);

      // Reset after three lanes have been issued
      issue(tbl[3].a, tbl[3].b, tbl[3].sub);
      @(negedge CLK);
      req_valid = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk1("mid_rst_req_ready", req_ready, 1'b1);
      chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk1("mid_rst_au_enable", au_enable, 1'b0);
      chkv("mid_rst_au_port_b", VW'(au_port_b), '0);
      chkv("mid_rst_rsp_out", rsp_out, '0);
      chk1("mid_rst_rsp_ovf", rsp_ovf, 1'b0);
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      issue(tbl[1].a, tbl[1].b, tbl[1].sub);
      collect(tbl[1].x, tbl[1].o, 1, 1'b0);

      // Reset while a result with overflow is pending
      issue(tbl[2].a, tbl[2].b, tbl[2].sub);
      collect(tbl[2].x, tbl[2].o, -1, 1'b0);
      nRST = 1'b0;
      #1;
      chk1("done_rst_rsp_valid", rsp_valid, 1'b0);
      chkv("done_rst_rsp_out", rsp_out, '0);
      chk1("done_rst_rsp_ovf", rsp_ovf, 1'b0);
      chk1("done_rst_req_ready", req_ready, 1'b1);
      @(negedge CLK);
      nRST = 1'b1;
      issue(tbl[3].a, tbl[3].b, tbl[3].sub);
      collect(tbl[3].x, tbl[3].o, 0, 1'b0);

      // Randomized ops against the lane-wise reference
      for (int n = 0; n < 25; n++) begin
         rs = 1'($urandom_range(0, 1));
         ro = 1'b0;
         for (int i = 0; i < LANES; i++) begin
            ra[16*i +: 16] = rand_h();
            rb[16*i +: 16] = rand_h();
            r = fp_addsub(ra[16*i +: 16], rb[16*i +: 16], rs);
            rx[16*i +: 16] = r[15:0];
            ro = ro | r[16];
         end
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         issue(ra, rb, rs);
         collect(rx, ro, int'($urandom_range(0, 3)), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
